// File: rtl/fdiv_if.sv
// fdiv_if: request/result bundle for the sequential single-precision divider.
//
// Handshake (one rule for the whole bundle):
//   The master may raise req with x/y valid in any cycle. The slave accepts
//   on a rising edge where req=1 and busy=0, and it raises busy on that same
//   edge. A req that is seen while busy=1 is dropped, not queued. The result
//   is delivered as a one-cycle valid pulse; rslt/flag are registered and
//   hold until the next valid. There is no result back-pressure. A new req
//   may be accepted in the valid cycle.
//
// Signals:
//   req       master->slave  start request
//   x, y      master->slave  dividend / divisor, IEEE single
//   busy      slave->master  operation in flight
//   valid     slave->master  one-cycle result pulse
//   rslt      slave->master  quotient, IEEE single
//   flag      slave->master  {NV, DZ, OF, UF, NX}
//   dbg_state slave->master  FSM state, for observation only
interface fdiv_if;
  logic        req;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        valid;
  logic [31:0] rslt;
  logic [4:0]  flag;
  logic [2:0]  dbg_state;

  modport master (
    output req, x, y,
    input  busy, valid, rslt, flag, dbg_state
  );

  modport slave (
    input  req, x, y,
    output busy, valid, rslt, flag, dbg_state
  );
endinterface

// File: rtl/fdiv.sv
// fdiv: sequential IEEE-754 single-precision divider, rslt = x / y.
//
// Radix-2 restoring iteration, one quotient bit per clock. Every operation,
// special operands included, takes exactly 29 clocks from the accepting edge
// to the edge that raises valid:
//   IDLE -> PRE (1) -> ALN (1) -> DIV (26) -> RND (1) -> IDLE
// PRE classifies the operands, normalises subnormal mantissas and forms the
// exponent; ALN pre-shifts the dividend so the quotient lies in [1,2) and
// loads the remainder; DIV produces 24 significand bits plus guard and round;
// RND denormalises tiny results, rounds to nearest-even and writes the flags.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset (abandons any operation)
//   bus    fdiv_if.slave: req/x/y in, busy/valid/rslt/flag/dbg_state out
module fdiv (
  input  logic    clk,
  input  logic    reset,
  fdiv_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ALN  = 3'd2,
    DIV  = 3'd3,
    RND  = 3'd4
  } state_t;

  state_t             state;
  logic [31:0]        xr, yr;
  logic [23:0]        mxn, myn;
  logic signed [9:0]  e;
  logic [25:0]        r;
  logic [25:0]        q;
  logic [4:0]         cnt;
  logic               spec_v;
  logic [31:0]        spec_rslt;
  logic [4:0]         spec_flag;
  logic               busy_r, valid_r;
  logic [31:0]        rslt_r;
  logic [4:0]         flag_r;

  // Leading-zero count of a 24-bit mantissa (24 when all zero).
  function automatic logic [4:0] lzc24(input logic [23:0] m);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++)
      if (m[i]) n = 5'(23 - i);
    return n;
  endfunction

  // ---------------- PRE: classify, normalise, exponent ----------------
  logic [7:0]        ex, ey;
  logic [22:0]       fx, fy;
  logic              x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, x_zero, y_zero;
  logic              sgn;
  logic [23:0]       mx_raw, my_raw;
  logic [4:0]        lzx, lzy;
  logic signed [9:0] ex_eff, ey_eff, e_pre;
  logic              pre_spec_v;
  logic [31:0]       pre_spec_rslt;
  logic [4:0]        pre_spec_flag;

  assign ex     = xr[30:23];
  assign ey     = yr[30:23];
  assign fx     = xr[22:0];
  assign fy     = yr[22:0];
  assign sgn    = xr[31] ^ yr[31];
  assign x_nan  = (&ex) & (|fx);
  assign y_nan  = (&ey) & (|fy);
  assign x_snan = x_nan & ~fx[22];
  assign y_snan = y_nan & ~fy[22];
  assign x_inf  = (&ex) & ~(|fx);
  assign y_inf  = (&ey) & ~(|fy);
  assign x_zero = ~(|ex) & ~(|fx);
  assign y_zero = ~(|ey) & ~(|fy);
  assign mx_raw = {|ex, fx};
  assign my_raw = {|ey, fy};
  assign lzx    = lzc24(mx_raw);
  assign lzy    = lzc24(my_raw);
  // A zero exponent field means exponent 1 for a subnormal; normalising then
  // lowers it by the shift amount.
  assign ex_eff = ((|ex) ? {2'b00, ex} : 10'sd1) - {5'b0, lzx};
  assign ey_eff = ((|ey) ? {2'b00, ey} : 10'sd1) - {5'b0, lzy};
  assign e_pre  = ex_eff - ey_eff + 10'sd127;

  always_comb begin
    pre_spec_v    = 1'b1;
    pre_spec_rslt = 32'h0;
    pre_spec_flag = 5'b0;
    if (x_nan) begin
      pre_spec_rslt = xr | 32'h0040_0000;
      pre_spec_flag = {x_snan | y_snan, 4'b0};
    end else if (y_nan) begin
      pre_spec_rslt = yr | 32'h0040_0000;
      pre_spec_flag = {y_snan, 4'b0};
    end else if ((x_zero & y_zero) | (x_inf & y_inf)) begin
      pre_spec_rslt = 32'hffc0_0000;
      pre_spec_flag = 5'b10000;
    end else if (x_inf) begin
      pre_spec_rslt = {sgn, 31'h7f80_0000};
    end else if (y_inf) begin
      pre_spec_rslt = {sgn, 31'h0};
    end else if (y_zero) begin
      pre_spec_rslt = {sgn, 31'h7f80_0000};
      pre_spec_flag = 5'b01000;
    end else if (x_zero) begin
      pre_spec_rslt = {sgn, 31'h0};
    end else begin
      pre_spec_v = 1'b0;
    end
  end

  // ---------------- DIV: one restoring step ----------------
  logic [26:0] diff;
  assign diff = {1'b0, r} - {3'b000, myn};

  // ---------------- RND: denormalise, round, flags ----------------
  logic              sticky0, e_le0, lost, st, g, rd, up, nx, tiny, of;
  logic signed [9:0] sh_raw;
  logic [4:0]        sh;
  logic [25:0]       qs;
  logic [23:0]       mant;
  logic [7:0]        ef;
  logic [30:0]       sum;
  logic [31:0]       res_rslt;
  logic [4:0]        res_flag;

  always_comb begin
    sticky0 = |r;
    e_le0   = (e <= 10'sd0);
    sh_raw  = 10'sd1 - e;
    sh      = 5'd0;
    if (e_le0) sh = (sh_raw > 10'sd26) ? 5'd26 : sh_raw[4:0];
    qs      = q >> sh;
    // Bits pushed out by the subnormal shift fold into sticky.
    lost    = |(q & ~(26'h3ff_ffff << sh));
    st      = sticky0 | lost;
    mant    = qs[25:2];
    g       = qs[1];
    rd      = qs[0];
    up      = g & (rd | st | mant[0]);
    nx      = g | rd | st;
    ef      = e_le0 ? 8'd0 : e[7:0];
    // Rounding carry ripples into the exponent field on its own.
    sum     = {ef, mant[22:0]} + 31'(up);
    of      = (e >= 10'sd255) | (&sum[30:23]);
    // Tininess judged after rounding to 24 bits with unbounded exponent:
    // at e==0 only an all-ones significand that rounds up escapes.
    tiny    = (e < 10'sd0) | ((e == 10'sd0) & ~(&q[25:1]));
    if (of) begin
      res_rslt = {sgn, 31'h7f80_0000};
      res_flag = 5'b00101;
    end else begin
      res_rslt = {sgn, sum};
      res_flag = {3'b000, tiny & nx, nx};
    end
  end

  // ---------------- control and datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      xr        <= '0;
      yr        <= '0;
      mxn       <= '0;
      myn       <= '0;
      e         <= '0;
      r         <= '0;
      q         <= '0;
      cnt       <= '0;
      spec_v    <= 1'b0;
      spec_rslt <= '0;
      spec_flag <= '0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      rslt_r    <= '0;
      flag_r    <= '0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            xr     <= bus.x;
            yr     <= bus.y;
            busy_r <= 1'b1;
            state  <= PRE;
          end
        end
        PRE: begin
          spec_v    <= pre_spec_v;
          spec_rslt <= pre_spec_rslt;
          spec_flag <= pre_spec_flag;
          mxn       <= mx_raw << lzx;
          myn       <= my_raw << lzy;
          e         <= e_pre;
          state     <= ALN;
        end
        ALN: begin
          // Doubling a smaller dividend keeps the quotient in [1,2).
          if (mxn < myn) begin
            r <= {1'b0, mxn, 1'b0};
            e <= e - 10'sd1;
          end else begin
            r <= {2'b00, mxn};
          end
          q     <= '0;
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          if (!diff[26]) begin
            q <= {q[24:0], 1'b1};
            r <= diff[25:0] << 1;
          end else begin
            q <= {q[24:0], 1'b0};
            r <= r << 1;
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25) state <= RND;
        end
        RND: begin
          rslt_r  <= spec_v ? spec_rslt : res_rslt;
          flag_r  <= spec_v ? spec_flag : res_flag;
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.valid     = valid_r;
  assign bus.rslt      = rslt_r;
  assign bus.flag      = flag_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: self-checking bench for fdiv.
// Directed cases carry hand-derived results; random cases are checked against
// an exact integer-quotient model with explicit round-to-nearest-even.
module tb_fdiv;

  logic clk;
  logic reset;
  fdiv_if bus ();

  fdiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [36:0] exp_q[$];

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Round an integer quotient qi (plus sticky) by dropping 'shift' low bits.
  function automatic void rnd_at(input logic [127:0] qi, input logic st_in, input int shift,
                                 output logic [127:0] kept, output logic inexact);
    logic [127:0] remb, half;
    if (shift >= 120) begin
      kept    = '0;
      inexact = (qi != 0) | st_in;
      return;
    end
    kept    = qi >> shift;
    remb    = qi - (kept << shift);
    half    = 128'd1 << (shift - 1);
    inexact = (remb != 0) | st_in;
    if ((remb > half) || ((remb == half) && (st_in || kept[0]))) kept = kept + 1;
  endfunction

  function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]   ea, eb;
    logic [22:0]  fa, fb;
    logic         s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0]  sa, sb;
    logic [127:0] num, qi, rem, k;
    logic         st, nx, tiny;
    int           xa, xb, p, biased, bu;
    ea = a[30:23]; fa = a[22:0];
    eb = b[30:23]; fb = b[22:0];
    s  = a[31] ^ b[31];
    a_nan  = (ea == 8'hff) && (fa != 0);
    b_nan  = (eb == 8'hff) && (fb != 0);
    a_snan = a_nan && !fa[22];
    b_snan = b_nan && !fb[22];
    a_inf  = (ea == 8'hff) && (fa == 0);
    b_inf  = (eb == 8'hff) && (fb == 0);
    a_zero = (ea == 0) && (fa == 0);
    b_zero = (eb == 0) && (fb == 0);
    if (a_nan) return {a | 32'h0040_0000, a_snan | b_snan, 4'b0};
    if (b_nan) return {b | 32'h0040_0000, b_snan, 4'b0};
    if ((a_zero && b_zero) || (a_inf && b_inf)) return {32'hffc0_0000, 5'b10000};
    if (a_inf)  return {s, 31'h7f80_0000, 5'b00000};
    if (b_inf)  return {s, 31'h0, 5'b00000};
    if (b_zero) return {s, 31'h7f80_0000, 5'b01000};
    if (a_zero) return {s, 31'h0, 5'b00000};
    sa = (ea == 0) ? {1'b0, fa} : {1'b1, fa};
    sb = (eb == 0) ? {1'b0, fb} : {1'b1, fb};
    xa = (ea == 0) ? 1 : int'(ea);
    xb = (eb == 0) ? 1 : int'(eb);
    // value(a)/value(b) = qi * 2^(xa-xb-60), exactly up to the remainder.
    num = {104'b0, sa} << 60;
    qi  = num / {104'b0, sb};
    rem = num % {104'b0, sb};
    st  = (rem != 0);
    p = 0;
    for (int i = 0; i < 128; i++) if (qi[i]) p = i;
    biased = p + xa - xb - 60 + 127;
    rnd_at(qi, st, p - 23, k, nx);
    bu   = biased + (k[24] ? 1 : 0);
    tiny = (bu < 1);
    if (biased >= 1) begin
      if (bu >= 255) return {s, 31'h7f80_0000, 5'b00101};
      return {s, 8'(bu), k[22:0], 3'b000, tiny & nx, nx};
    end
    rnd_at(qi, st, p - 23 + 1 - biased, k, nx);
    return {s, 31'(k), 3'b000, tiny & nx, nx};
  endfunction

  function automatic logic [31:0] rand_op();
    int          sel;
    logic        s;
    logic [22:0] f;
    logic [7:0]  e;
    sel = $urandom_range(0, 11);
    s   = 1'($urandom_range(0, 1));
    f   = 23'($urandom);
    e   = 8'($urandom_range(1, 254));
    case (sel)
      0:       return {s, 31'h0};
      1:       return {s, 8'hff, 23'h0};
      2:       return {s, 8'hff, f | 23'h1};
      3, 4:    return {s, 8'h00, f};
      5:       return {s, 8'($urandom_range(248, 254)), f};
      6:       return {s, 8'($urandom_range(1, 6)), f};
      default: return {s, e, f};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge with busy low; returns #1 after the accept.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [36:0] expv);
    bus.req = 1'b1;
    bus.x   = a;
    bus.y   = b;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  // Waits (bounded) for valid; start_k = edges already elapsed since accept.
  task automatic await_result(input string tag, input int start_k);
    int          k, bcnt;
    logic [36:0] e;
    k    = start_k;
    bcnt = start_k;
    while (!bus.valid && k < 45) begin
      @(posedge clk); #1;
      k++;
      if (bus.busy) bcnt++;
    end
    check({tag, "_latency"}, 32'(k), 32'd29);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd28);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h0;
    if (bus.valid) begin
      check({tag, "_rslt"}, bus.rslt, e[36:5]);
      check({tag, "_flag"}, 32'(bus.flag), 32'(e[4:0]));
    end
  endtask

  // ---------------- directed cases ----------------
  localparam int ND = 7;
  logic [31:0] d_x [ND] = '{32'h3f800000, 32'h00000000, 32'h7f800001, 32'h00800000,
                            32'h00000001, 32'h00000001, 32'h7f7fffff};
  logic [31:0] d_y [ND] = '{32'h80000000, 32'h00000000, 32'h3f800000, 32'h40000000,
                            32'h40000000, 32'h00000002, 32'h3f000000};
  logic [31:0] d_r [ND] = '{32'hff800000, 32'hffc00000, 32'h7fc00001, 32'h00400000,
                            32'h00000000, 32'h3f000000, 32'h7f800000};
  logic [4:0]  d_f [ND] = '{5'h08, 5'h10, 5'h10, 5'h00, 5'h03, 5'h00, 5'h05};

  initial begin
    int pulses;
    logic [31:0] a, b;
    reset   = 1'b1;
    bus.req = 1'b0;
    bus.x   = '0;
    bus.y   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_rslt", bus.rslt, 32'd0);
    check("reset_flag", 32'(bus.flag), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 6.0 / 2.0
    issue(32'h40c00000, 32'h40000000, {32'h40400000, 5'h00});
    await_result("six_by_two", 0);

    // 1/3, then back-to-back issue in the valid cycle
    issue(32'h3f800000, 32'h40400000, {32'h3eaaaaab, 5'h01});
    await_result("one_third", 0);
    issue(32'h3f800000, 32'h3f800000, {32'h3f800000, 5'h00});
    await_result("b2b_one", 0);

    for (int i = 0; i < ND; i++) begin
      issue(d_x[i], d_y[i], {d_r[i], d_f[i]});
      await_result($sformatf("dir%0d", i), 0);
    end

    // req while busy must be dropped
    issue(32'h40c00000, 32'h40000000, {32'h40400000, 5'h00});
    repeat (10) @(posedge clk);
    #1;
    bus.req = 1'b1;
    bus.x   = 32'h3f800000;
    bus.y   = 32'h3f800000;
    @(posedge clk); #1;
    bus.req = 1'b0;
    await_result("drop_req", 11);
    pulses = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (bus.valid) pulses++;
    end
    check("drop_req_extra_valid", 32'(pulses), 32'd0);
    check("drop_req_idle", 32'(bus.busy), 32'd0);

    // reset in clock 15 of an operation
    issue(32'h3f800000, 32'h40400000, {32'h3eaaaaab, 5'h01});
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_valid", 32'(bus.valid), 32'd0);
    check("midreset_rslt", bus.rslt, 32'd0);
    check("midreset_flag", 32'(bus.flag), 32'd0);
    #2;
    reset = 1'b0;
    void'(exp_q.pop_front());
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.valid) pulses++;
    end
    check("midreset_no_valid", 32'(pulses), 32'd0);

    issue(32'h40c00000, 32'h40000000, {32'h40400000, 5'h00});
    await_result("after_reset", 0);

    // random operands against the model
    for (int i = 0; i < 60; i++) begin
      a = rand_op();
      b = rand_op();
      issue(a, b, ref_div(a, b));
      await_result($sformatf("rnd%0d_%h_%h", i, a, b), 0);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
